// File: rtl/mult_booth.sv
// Sequential signed radix-2 Booth multiplier.
// One Booth step per clock; a WIDTH x WIDTH product takes WIDTH steps,
// followed by a single DONE cycle that pulses mult_done.
module mult_booth #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic [WIDTH-1:0] mult_a,
    input  logic [WIDTH-1:0] mult_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             mult_done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state;
    logic [WIDTH:0]   m_reg;   // sign-extended multiplicand
    logic [WIDTH:0]   a_reg;   // accumulator, one bit wider so -2^(WIDTH-1) cannot overflow
    logic [WIDTH-1:0] q_reg;   // multiplier, shifts out towards q_m1
    logic             q_m1;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   a_sum;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             q_m1_next;

    // Booth add/subtract followed by arithmetic right shift of {A,Q,q_m1}
    always_comb begin
        a_sum = a_reg;
        unique case ({q_reg[0], q_m1})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg - m_reg;
            default: a_sum = a_reg;
        endcase
        a_next    = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_next    = {a_sum[0], q_reg[WIDTH-1:1]};
        q_m1_next = q_reg[0];
    end

    // busy covers both the stepping phase and the completion cycle
    always_comb begin
        busy = (state != StIdle);
    end

    // Control FSM, datapath registers and registered result/done outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            q_m1      <= 1'b0;
            count     <= '0;
            hi        <= '0;
            lo        <= '0;
            mult_done <= 1'b0;
        end else begin
            mult_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (mult_start) begin
                        m_reg <= {mult_a[WIDTH-1], mult_a};
                        a_reg <= '0;
                        q_reg <= mult_b;
                        q_m1  <= 1'b0;
                        count <= '0;
                        state <= StRun;
                    end
                end
                StRun: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_m1  <= q_m1_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        hi        <= a_next[WIDTH-1:0];
                        lo        <= q_next;
                        mult_done <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    // start requests here are dropped, not queued
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth: stimulus pushes hand-computed products,
// a monitor pops and compares on every mult_done pulse.
module tb_mult_booth;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             mult_start;
    logic [WIDTH-1:0] mult_a;
    logic [WIDTH-1:0] mult_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             mult_done;

    mult_booth #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .mult_done  (mult_done)
    );

    always #5 clk = ~clk;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          done_cnt  = 0;
    int          pushed    = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res  = 64'h0;
    bit          held_ok   = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Called at a negedge: start is held across exactly one rising edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [63:0] exp);
        mult_a     = a;
        mult_b     = b;
        mult_start = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            pushed++;
        end
        @(negedge clk);
        mult_start = 1'b0;
    endtask

    // Counts busy cycles until idle; bounded so a stuck DUT still reaches the summary
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 100) check("idle_timeout", 64'(busy), 64'h0);
    endtask

    // Monitor: compare result on each done pulse, and verify hi/lo held during RUN
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (mult_done) begin
                done_cnt++;
                check("hold_during_run", 64'(held_ok), 64'h1);
                held_ok = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {hi, lo}, 64'hx);
                end else begin
                    last_res = exp_q.pop_front();
                    check("product", {hi, lo}, last_res);
                end
            end else if (busy && ({hi, lo} !== last_res)) begin
                held_ok = 1'b0;
            end
        end
    end

    initial begin
        int cyc;
        reset      = 1'b0;
        mult_start = 1'b0;
        mult_a     = '0;
        mult_b     = '0;
        #3;
        check("reset_outputs", {hi, lo}, 64'h0);
        check("reset_flags", {62'h0, busy, mult_done}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 3 x 5, also measures busy length
        issue(32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F);
        wait_idle(cyc);
        check("busy_cycles", 64'(cyc), 64'd33);

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle(cyc);
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle(cyc);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        wait_idle(cyc);
        issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001);
        wait_idle(cyc);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);
        wait_idle(cyc);

        // 6 x 7 with a stray start and operand change mid-run
        issue(32'd6, 32'd7, 1'b1, 64'd42);
        repeat (9) @(negedge clk);
        mult_a     = 32'd2;
        mult_b     = 32'd2;
        mult_start = 1'b1;
        @(negedge clk);
        mult_start = 1'b0;
        wait_idle(cyc);
        check("stray_start_busy", 64'(cyc), 64'd23);

        // Back-to-back: start in the first IDLE cycle must be accepted
        issue(32'd2, 32'd2, 1'b1, 64'd4);
        check("b2b_accepted", 64'(busy), 64'h1);
        wait_idle(cyc);

        // 9 x 9 abandoned by asynchronous reset mid-run
        issue(32'd9, 32'd9, 1'b0, 64'h0);
        repeat (14) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_result", {hi, lo}, 64'h0);
        check("async_reset_flags", {62'h0, busy, mult_done}, 64'h0);
        last_res = 64'h0;
        held_ok  = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(32'd9, 32'd9, 1'b1, 64'd81);
        wait_idle(cyc);
        check("post_reset_busy", 64'(cyc), 64'd33);

        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_cnt), 64'(pushed));
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
